// File: rtl/avalon_arb_pkg.sv
// Shared types for the two-master Avalon-MM arbiter.
package avalon_arb_pkg;

   localparam int NBMASTERS = 2;

   typedef enum logic {IDLE, BUSY} arb_state_t;

   typedef logic master_id_t;

   // Round-robin pick: the master that did not win last time has priority.
   // Only meaningful when at least one request bit is set.
   function automatic master_id_t rr_pick(input logic [NBMASTERS-1:0] req,
                                          input master_id_t           last);
      master_id_t other;
      other = ~last;
      return req[other] ? other : last;
   endfunction

endpackage

// File: rtl/avalon_arb_id_fifo.sv
// Master-ID FIFO for outstanding reads; head is read combinationally.
module avalon_arb_id_fifo
   import avalon_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_i,
   input  master_id_t din_i,
   input  logic       pop_i,
   output master_id_t head_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [DEPTH-1:0] mem_q;
   logic [AW-1:0]    rd_q, wr_q;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == DEPTH_C);
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_q];
   assign do_pop  = pop_i & ~empty_o;
   // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
   assign do_push = push_i & (~full_o | do_pop);

   // Occupancy follows the accepted push/pop pair.
   always_comb begin
      cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
   end

   // Storage and pointers; power-of-2 depth lets the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter with round-robin grant and
// read-ID tracking so returned data only flags the issuing master.
module avalon_mm_arbiter
   import avalon_arb_pkg::*;
#(
   parameter  int NBDATABYTES = 2,
   parameter  int NBADDRBITS  = 8,
   parameter  int MAXPENDING  = 4,
   localparam int DW          = 8*NBDATABYTES
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NBMASTERS-1:0][NBADDRBITS-1:0]   m_address,
   input  logic [NBMASTERS-1:0][NBDATABYTES-1:0]  m_byteenable,
   input  logic [NBMASTERS-1:0]                   m_read,
   input  logic [NBMASTERS-1:0]                   m_write,
   input  logic [NBMASTERS-1:0][DW-1:0]           m_writedata,
   output logic [NBMASTERS-1:0][DW-1:0]           m_readdata,
   output logic [NBMASTERS-1:0]                   m_readdatavalid,
   output logic [NBMASTERS-1:0]                   m_waitrequest,
   output logic [NBADDRBITS-1:0]                  s_address,
   output logic [NBDATABYTES-1:0]                 s_byteenable,
   output logic                                   s_read,
   output logic                                   s_write,
   output logic [DW-1:0]                          s_writedata,
   input  logic [DW-1:0]                          s_readdata,
   input  logic                                   s_readdatavalid,
   input  logic                                   s_waitrequest,
   output logic                                   err_unexpected
);

   arb_state_t           state_q, state_d;
   master_id_t           grant_q, grant_d;
   master_id_t           last_q, last_d;
   logic                 err_q, err_d;
   logic [NBMASTERS-1:0] req, req_other;
   logic                 busy, rw_both, accept, push, pop;
   logic                 fifo_full, fifo_empty;
   master_id_t           fifo_head;

   assign busy    = (state_q == BUSY);
   assign rw_both = busy & m_read[grant_q] & m_write[grant_q];

   // A read only competes while there is room to remember who issued it.
   always_comb begin
      for (int i = 0; i < NBMASTERS; i++)
         req[i] = m_write[i] | (m_read[i] & ~fifo_full);
      req_other          = req;
      req_other[grant_q] = 1'b0;
   end

   // Forward the granted command; read+write together forwards only the write.
   always_comb begin
      s_write      = busy & m_write[grant_q];
      s_read       = busy & m_read[grant_q] & ~m_write[grant_q] & ~fifo_full;
      s_address    = busy ? m_address[grant_q]    : '0;
      s_byteenable = busy ? m_byteenable[grant_q] : '0;
      s_writedata  = busy ? m_writedata[grant_q]  : '0;
   end

   assign accept = (s_read | s_write) & ~s_waitrequest;
   assign push   = accept & s_read;
   assign pop    = s_readdatavalid & ~fifo_empty;

   // Only the granted master can see waitrequest drop, and only on accept.
   always_comb begin
      m_waitrequest = '1;
      if (busy) m_waitrequest[grant_q] = ~accept;
   end

   // Returned data goes to every master; the valid strobe only to the issuer.
   always_comb begin
      m_readdatavalid = '0;
      if (pop) m_readdatavalid[fifo_head] = 1'b1;
   end

   assign m_readdata     = {NBMASTERS{s_readdata}};
   assign err_unexpected = err_q;

   // Next-state: grant from IDLE, re-arbitrate on accept, bail if the
   // granted master withdraws without being accepted.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      err_d   = err_q | (s_readdatavalid & fifo_empty) | rw_both;
      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d = rr_pick(req, last_q);
               last_d  = grant_d;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (accept) begin
               if (|req_other) begin
                  grant_d = ~grant_q;
                  last_d  = ~grant_q;
               end else begin
                  state_d = IDLE;
               end
            end else if (!(s_read | s_write)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Arbiter state, grant history and sticky error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         err_q   <= err_d;
      end
   end

   avalon_arb_id_fifo #(.DEPTH(MAXPENDING)) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (push),
      .din_i   (grant_q),
      .pop_i   (pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Bench for avalon_mm_arbiter: master/slave BFMs, a transaction-level
// model checked every cycle, and directed scenarios with literal results.
`timescale 1ns/1ps
module tb_avalon_mm_arbiter;

   localparam int NB = 2;
   localparam int AB = 8;
   localparam int MP = 4;
   localparam int DW = 16;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [1:0][AB-1:0]     m_address;
   logic [1:0][NB-1:0]     m_byteenable;
   logic [1:0]             m_read, m_write;
   logic [1:0][DW-1:0]     m_writedata;
   logic [1:0][DW-1:0]     m_readdata;
   logic [1:0]             m_readdatavalid, m_waitrequest;
   logic [AB-1:0]          s_address;
   logic [NB-1:0]          s_byteenable;
   logic                   s_read, s_write;
   logic [DW-1:0]          s_writedata, s_readdata;
   logic                   s_readdatavalid, s_waitrequest;
   logic                   err_unexpected;

   avalon_mm_arbiter #(.NBDATABYTES(NB), .NBADDRBITS(AB), .MAXPENDING(MP)) dut (
      .clk(clk), .rst(rst),
      .m_address(m_address), .m_byteenable(m_byteenable), .m_read(m_read),
      .m_write(m_write), .m_writedata(m_writedata), .m_readdata(m_readdata),
      .m_readdatavalid(m_readdatavalid), .m_waitrequest(m_waitrequest),
      .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
      .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata),
      .s_readdatavalid(s_readdatavalid), .s_waitrequest(s_waitrequest),
      .err_unexpected(err_unexpected)
   );

   always #5 clk = ~clk;

   typedef struct {logic rd; logic wr; logic [AB-1:0] addr; logic [NB-1:0] be; logic [DW-1:0] data;} cmd_t;
   typedef struct {int cyc; logic [DW-1:0] data;} resp_t;
   typedef struct {int cyc; int mst; logic rd; logic [AB-1:0] addr;} acc_t;

   cmd_t          mq0[$], mq1[$];
   resp_t         rq[$];
   acc_t          acc_log[$];
   int            rdv_mst[$];
   logic [DW-1:0] rdv_dat[$];
   logic [9:0]    trace[$];
   int            exp_id[$];
   logic          err_exp;
   logic [1:0]    acc_seen = '0;
   int            cyc = 0;
   int            stall_cnt = 0;
   logic          resp_en = 1'b1;
   logic          orphan = 1'b0;
   int            checks = 0;
   int            failures = 0;

   cmd_t          c0, c1, cnew;
   resp_t         rnew;
   acc_t          anew;
   logic          acc_b, pop_b;
   logic [1:0]    exp_rdv;
   int            nacc, newsz, cr;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Master and slave BFMs: drive one time unit after each rising edge.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (acc_seen[0] && mq0.size() > 0) void'(mq0.pop_front());
      if (acc_seen[1] && mq1.size() > 0) void'(mq1.pop_front());
      acc_seen = '0;
      c0 = '{1'b0, 1'b0, '0, '0, '0};
      c1 = '{1'b0, 1'b0, '0, '0, '0};
      if (mq0.size() > 0) c0 = mq0[0];
      if (mq1.size() > 0) c1 = mq1[0];
      m_read       = {c1.rd, c0.rd};
      m_write      = {c1.wr, c0.wr};
      m_address    = {c1.addr, c0.addr};
      m_byteenable = {c1.be, c0.be};
      m_writedata  = {c1.data, c0.data};
      s_waitrequest   = (stall_cnt > 0);
      s_readdatavalid = 1'b0;
      s_readdata      = '0;
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
         s_readdatavalid = 1'b1;
         s_readdata      = rq[0].data;
         void'(rq.pop_front());
      end else if (orphan) begin
         s_readdatavalid = 1'b1;
         s_readdata      = 16'hDEAD;
      end
      orphan = 1'b0;
   end

   // Transaction-level model and per-cycle compare.
   always @(negedge clk) begin
      if (!rst) begin
         exp_id.delete();
         err_exp  = 1'b0;
         acc_seen = '0;
      end else begin
         acc_b = (s_read | s_write) & ~s_waitrequest;
         pop_b = s_readdatavalid && exp_id.size() > 0;
         chk("err_flag", err_unexpected, err_exp);
         chk("rd_wr_excl", s_read & s_write, 0);
         nacc = int'(!m_waitrequest[0]) + int'(!m_waitrequest[1]);
         chk("accept_count", nacc, acc_b);
         exp_rdv = '0;
         if (pop_b) exp_rdv[exp_id[0]] = 1'b1;
         chk("rdv_route", m_readdatavalid, exp_rdv);
         chk("rdata_bcast", m_readdata, {s_readdata, s_readdata});
         if (s_read | s_write) trace.push_back({s_read, s_write, s_address});
         if (m_readdatavalid != 0) begin
            rdv_mst.push_back(m_readdatavalid[1] ? 1 : 0);
            rdv_dat.push_back(m_readdata[0]);
         end
         if (s_readdatavalid && exp_id.size() == 0) err_exp = 1'b1;
         for (int i = 0; i < 2; i++)
            if (s_write && m_read[i] && m_write[i] && !m_read[1-i] && !m_write[1-i]) err_exp = 1'b1;
         for (int i = 0; i < 2; i++) begin
            if (!m_waitrequest[i]) begin
               chk("fwd_addr", s_address, m_address[i]);
               chk("fwd_be", s_byteenable, m_byteenable[i]);
               chk("fwd_wr", s_write, m_write[i]);
               chk("fwd_rd", s_read, m_read[i] & ~m_write[i]);
               if (m_write[i]) chk("fwd_wdata", s_writedata, m_writedata[i]);
               anew.cyc = cyc; anew.mst = i; anew.rd = s_read; anew.addr = s_address;
               acc_log.push_back(anew);
               if (s_read) begin
                  newsz = exp_id.size() + 1 - int'(pop_b);
                  chk("pending_bound", newsz <= MP, 1);
                  if (resp_en) begin
                     rnew.cyc = cyc + 2; rnew.data = {4{s_address[3:0]}};
                     rq.push_back(rnew);
                  end
               end
            end
         end
         if (pop_b) void'(exp_id.pop_front());
         for (int i = 0; i < 2; i++) if (!m_waitrequest[i] && s_read) exp_id.push_back(i);
         acc_seen = ~m_waitrequest;
         if ((s_read | s_write) && s_waitrequest && stall_cnt > 0) stall_cnt--;
      end
   end

   task automatic rst_pulse();
      @(negedge clk);
      rst = 1'b0;
      mq0.delete(); mq1.delete(); rq.delete();
      stall_cnt = 0; resp_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      acc_log.delete(); trace.delete(); rdv_mst.delete(); rdv_dat.delete();
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic cmd_t mk(input logic rd, input logic wr, input logic [AB-1:0] a,
                               input logic [DW-1:0] d);
      cmd_t c;
      c.rd = rd; c.wr = wr; c.addr = a; c.be = 2'b11; c.data = d;
      return c;
   endfunction

   initial begin
      rst = 1'b0;
      run(2);
      // reset values
      chk("reset_outputs",
          {s_read, s_write, m_waitrequest, m_readdatavalid, err_unexpected, s_address, s_byteenable, s_writedata},
          {1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 8'h00, 2'b00, 16'h0000});
      rst = 1'b1;

      // single write, zero-wait slave
      rst_pulse();
      mq0.push_back(mk(1'b0, 1'b1, 8'h10, 16'hBEEF));
      run(1);
      chk("t1_idle_first", s_write, 0);
      run(1);
      chk("t1_write_cycle", {s_write, s_address, s_writedata, m_waitrequest}, {1'b1, 8'h10, 16'hBEEF, 2'b10});
      run(1);
      chk("t1_one_cycle", s_write, 0);

      // both masters write continuously: strict alternation, no gaps
      rst_pulse();
      for (int k = 0; k < 4; k++) begin
         mq0.push_back(mk(1'b0, 1'b1, 8'h00 + 8'(k), 16'h1000 + 16'(k)));
         mq1.push_back(mk(1'b0, 1'b1, 8'h80 + 8'(k), 16'h2000 + 16'(k)));
      end
      run(14);
      chk("t2_accepts", acc_log.size(), 8);
      for (int k = 0; k < acc_log.size() && k < 8; k++) begin
         chk("t2_master", acc_log[k].mst, k % 2);
         if (k > 0) chk("t2_gap", acc_log[k].cyc - acc_log[k-1].cyc, 1);
      end

      // m1 read stalled 3 cycles while m0 waits
      rst_pulse();
      stall_cnt = 3;
      mq1.push_back(mk(1'b1, 1'b0, 8'h20, 16'h0));
      run(1);
      mq0.push_back(mk(1'b0, 1'b1, 8'h30, 16'h5A5A));
      run(10);
      chk("t3_trace_len", trace.size(), 5);
      for (int k = 0; k < 4 && k < trace.size(); k++) chk("t3_read_held", trace[k], {1'b1, 1'b0, 8'h20});
      if (trace.size() > 4) chk("t3_then_m0", trace[4], {1'b0, 1'b1, 8'h30});
      chk("t3_acc_n", acc_log.size(), 2);
      if (acc_log.size() >= 2) chk("t3_order", {acc_log[0].mst, acc_log[1].mst}, {32'd1, 32'd0});

      // pipelined reads return to the issuing master in order
      rst_pulse();
      mq0.push_back(mk(1'b1, 1'b0, 8'h01, 16'h0));
      mq0.push_back(mk(1'b1, 1'b0, 8'h03, 16'h0));
      mq1.push_back(mk(1'b1, 1'b0, 8'h02, 16'h0));
      run(12);
      chk("t4_rdv_n", rdv_mst.size(), 3);
      if (rdv_mst.size() == 3) begin
         chk("t4_rdv_mst", {rdv_mst[0], rdv_mst[1], rdv_mst[2]}, {32'd0, 32'd1, 32'd0});
         chk("t4_rdv_dat", {rdv_dat[0], rdv_dat[1], rdv_dat[2]}, {16'h1111, 16'h2222, 16'h3333});
      end

      // FIFO full: fifth read waits for the first return
      rst_pulse();
      resp_en = 1'b0;
      for (int k = 0; k < 5; k++) mq0.push_back(mk(1'b1, 1'b0, 8'h40 + 8'(k), 16'h0));
      run(14);
      chk("t5_four_accepted", acc_log.size(), 4);
      chk("t5_stalled", m_waitrequest[0], 1);
      orphan = 1'b1;
      cr = cyc + 1;
      run(6);
      chk("t5_fifth_accepted", acc_log.size(), 5);
      if (acc_log.size() == 5) chk("t5_not_early", acc_log[4].cyc >= cr, 1);
      chk("t5_return_m0", (rdv_mst.size() == 1) ? rdv_mst[0] : -1, 0);

      // orphan readdatavalid sets a sticky error; reset mid-BUSY
      rst_pulse();
      orphan = 1'b1;
      run(3);
      chk("t6_err_set", err_unexpected, 1);
      run(3);
      chk("t6_err_sticky", err_unexpected, 1);
      stall_cnt = 100;
      mq0.push_back(mk(1'b0, 1'b1, 8'h77, 16'h1357));
      run(3);
      chk("t6_busy_stalled", {s_write, s_address}, {1'b1, 8'h77});
      rst = 1'b0;
      #1;
      chk("t6_async_reset",
          {s_read, s_write, m_waitrequest, m_readdatavalid, err_unexpected, s_address, s_writedata},
          {1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 8'h00, 16'h0000});
      mq0.delete(); stall_cnt = 0;
      run(2);
      rst = 1'b1;
      // reset flushes a pending read; its late return is an orphan
      resp_en = 1'b0;
      mq0.push_back(mk(1'b1, 1'b0, 8'h09, 16'h0));
      run(5);
      chk("t6_read_issued", acc_log.size(), 1);
      rst_pulse();
      orphan = 1'b1;
      run(3);
      chk("t6_flush_orphan_err", err_unexpected, 1);
      chk("t6_flush_no_rdv", rdv_mst.size(), 0);

      // read+write together: only the write goes out, error flagged
      rst_pulse();
      cnew = mk(1'b1, 1'b1, 8'h55, 16'h1234);
      cnew.be = 2'b01;
      mq0.push_back(cnew);
      run(5);
      chk("t7_trace", (trace.size() > 0) ? trace[0] : 10'h3FF, {1'b0, 1'b1, 8'h55});
      chk("t7_err", err_unexpected, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
